// File: rtl/sc2bin10bit_if.sv
// Handshake and data bundle between a bitstream source and the
// stochastic-to-binary decoder.
interface sc2bin10bit_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             bs;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] scalar;
  logic             sat;

  modport master (
    output start,
    output bs,
    input  busy,
    input  valid,
    input  scalar,
    input  sat
  );

  modport slave (
    input  start,
    input  bs,
    output busy,
    output valid,
    output scalar,
    output sat
  );
endinterface

// File: rtl/sc2bin10bit.sv
// Stochastic-to-binary decoder: counts the ones in a unipolar bitstream over
// a window of 2^WIDTH consecutive samples and reports the count, saturated
// to 2^WIDTH-1, together with a flag marking an all-ones window.
module sc2bin10bit #(
  parameter int WIDTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  sc2bin10bit_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [WIDTH-1:0] LAST_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FIRST_CNT = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   FULL     = {1'b1, {WIDTH{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] scalar_q, scalar_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH:0]   total;

  // Next-state logic: a window opens on start from IDLE or DONE, with the
  // bit at the accepting edge taken as sample 0, so back-to-back windows
  // lose no bits; the last sample closes the window and loads the result.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    scalar_d = scalar_q;
    sat_d    = sat_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    total    = ones_q + {{WIDTH{1'b0}}, bus.bs};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ones_d  = {{WIDTH{1'b0}}, bus.bs};
          cnt_d   = FIRST_CNT;
          busy_d  = 1'b1;
          state_d = COUNT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (cnt_q == LAST_CNT) begin
          scalar_d = (total == FULL) ? LAST_CNT : total[WIDTH-1:0];
          sat_d    = (total == FULL);
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          ones_d   = '0;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          ones_d = total;
          cnt_d  = cnt_q + FIRST_CNT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        ones_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any open window and clears
  // the previously reported result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      cnt_q    <= '0;
      scalar_q <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
      scalar_q <= scalar_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.scalar = scalar_q;
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_sc2bin10bit.sv
// Directed bench for the stochastic-to-binary decoder, fed either by a
// constant bit or by a 10-bit van der Corput bitstream source.
module tb_sc2bin10bit;

  logic       clk = 1'b0;
  logic       reset;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         phase = 0;
  logic       bs_mode;
  logic       bs_const;
  logic [9:0] vdc_val;
  int         lat;
  int         vcount;
  logic [9:0] b2b_vals [3];

  always #5 clk = ~clk;

  sc2bin10bit_if #(.WIDTH(10)) bus ();

  sc2bin10bit #(.WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [9:0] bitrev(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the bit for the next edge, take that edge, return at the negedge.
  task automatic tick();
    logic [9:0] ph;
    ph = phase[9:0];
    if (bs_mode) bus.bs = (vdc_val > bitrev(ph));
    else         bus.bs = bs_const;
    @(posedge clk);
    phase++;
    @(negedge clk);
  endtask

  task automatic run_window(input string tag, input logic [9:0] exp_s,
                            input logic exp_sat, input int extra_a, input int extra_b);
    int l;
    int busy_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    l = 0;
    busy_cnt = 0;
    while (bus.valid !== 1'b1 && l < 2000) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (l + 1 == extra_a) || (l + 1 == extra_b);
      tick();
      l++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, l, 1023);
    check({tag, " busy cycles"}, busy_cnt, 1023);
    check({tag, " scalar"}, bus.scalar, exp_s);
    check({tag, " sat"}, bus.sat, exp_sat);
    check({tag, " busy at valid"}, bus.busy, 0);
    tick();
    check({tag, " valid pulse width"}, bus.valid, 0);
    check({tag, " held scalar"}, bus.scalar, exp_s);
    tick();
    check({tag, " idle busy"}, bus.busy, 0);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.bs    = 1'b0;
    bs_mode   = 1'b0;
    bs_const  = 1'b0;
    vdc_val   = '0;
    b2b_vals[0] = 10'd700;
    b2b_vals[1] = 10'd41;
    b2b_vals[2] = 10'd999;

    #12;
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.valid, 0);
    check("reset scalar", bus.scalar, 0);
    check("reset sat", bus.sat, 0);
    @(negedge clk);
    reset = 1'b1;

    // Constant streams.
    bs_const = 1'b0;
    run_window("const0", 10'd0, 1'b0, -1, -1);
    bs_const = 1'b1;
    run_window("const1", 10'd1023, 1'b1, -1, -1);
    bs_const = 1'b0;
    run_window("const0 after ones", 10'd0, 1'b0, -1, -1);

    // VDC source at arbitrary phases.
    bs_mode = 1'b1;
    vdc_val = 10'd300;  repeat (37)  tick(); run_window("vdc300", 10'd300, 1'b0, -1, -1);
    vdc_val = 10'd0;    repeat (5)   tick(); run_window("vdc0", 10'd0, 1'b0, -1, -1);
    vdc_val = 10'd1;    repeat (123) tick(); run_window("vdc1", 10'd1, 1'b0, -1, -1);
    vdc_val = 10'd512;  repeat (400) tick(); run_window("vdc512", 10'd512, 1'b0, -1, -1);
    vdc_val = 10'd1023; repeat (1)   tick(); run_window("vdc1023", 10'd1023, 1'b0, -1, -1);

    // Back-to-back windows with start held; source value switches at DONE.
    vdc_val = b2b_vals[0];
    repeat (77) tick();
    bus.start = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      lat = 0;
      while (bus.valid !== 1'b1 && lat < 2000) begin
        tick();
        lat++;
      end
      check("b2b latency", lat, 1023);
      check("b2b scalar", bus.scalar, b2b_vals[w]);
      check("b2b sat", bus.sat, 0);
      if (w < 2) vdc_val = b2b_vals[w+1];
      else       bus.start = 1'b0;
      tick();
      check("b2b reopen busy", bus.busy, (w < 2) ? 1 : 0);
      check("b2b valid low", bus.valid, 0);
    end

    // Reset in the middle of an all-ones window.
    bs_mode  = 1'b0;
    bs_const = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (499) tick();
    check("midreset busy before", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("midreset busy", bus.busy, 0);
    check("midreset valid", bus.valid, 0);
    check("midreset scalar", bus.scalar, 0);
    check("midreset sat", bus.sat, 0);
    repeat (3) tick();
    reset = 1'b1;
    vcount = 0;
    repeat (600) begin
      tick();
      if (bus.valid === 1'b1) vcount++;
    end
    check("midreset no valid", vcount, 0);
    check("midreset idle busy", bus.busy, 0);
    run_window("after reset ones", 10'd1023, 1'b1, -1, -1);

    // Stray start pulses during an open window are ignored.
    bs_mode = 1'b1;
    vdc_val = 10'd512;
    repeat (19) tick();
    run_window("stray starts", 10'd512, 1'b0, 10, 600);
    vcount = 0;
    repeat (1100) begin
      tick();
      if (bus.valid === 1'b1 || bus.busy === 1'b1) vcount++;
    end
    check("stray starts stay idle", vcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sc2bin10bit.md
# sc2bin10bit

Stochastic-to-binary decoder for the HDC bitstream datapath: counts the ones in a unipolar bitstream over one full window of 2^WIDTH clock cycles and returns the count as a WIDTH-bit scalar. It is the receive side of the 10-bit van der Corput bitstream generator. Because that generator cycles through all 2^WIDTH comparison values once per period, any 2^WIDTH consecutive bits from it decode to exactly the original scalar, regardless of phase. It is used for loopback checking and for converting bundled/bound hypervector bitstreams back to binary.

## Interface
- WIDTH, 10, scalar width; window length N = 2^WIDTH cycles.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset = 0 resets the block).
- start  in  1  request to decode a window; level-sampled at rising edge, accepted only in IDLE or DONE.
- bs  in  1  stochastic bitstream input, sampled every rising edge while a window is open.
- busy  out  1  high while a window is open (COUNT state).
- valid  out  1  one-cycle pulse: scalar/sat updated this cycle.
- scalar  out  WIDTH  decoded ones count, saturated to 2^WIDTH-1; held until next result.
- sat  out  1  set with valid when the true count was 2^WIDTH (all ones); held with scalar.

## Operation
- States: IDLE, COUNT, DONE; reset → IDLE.
- Internal: ones accumulator (WIDTH+1 bits), sample counter cnt (WIDTH bits), result registers.
- IDLE: start=1 at an edge → accept. The bs value at that same edge is sample 0: ones ← bs, cnt ← 1, state ← COUNT, busy ← 1. With start=0, stay in IDLE.
- COUNT, cnt < N-1: ones ← ones + bs, cnt ← cnt+1. start is ignored.
- COUNT, cnt = N-1 (final sample):
  - total = ones + bs, which ranges 0..N.
  - scalar ← (total = N) ? N-1 : total[WIDTH-1:0].
  - sat ← (total = N).
  - valid ← 1, busy ← 0, state ← DONE.
- DONE lasts exactly one cycle; valid = 1 for that cycle.
  - At the DONE edge, valid ← 0.
  - If start = 1, accept exactly as from IDLE (sample 0 taken at this edge, state ← COUNT). Back-to-back windows are therefore contiguous, with no dropped bit.
  - Otherwise state ← IDLE.
- Window = exactly N samples, taken at N consecutive rising edges starting at the accepting edge.
- scalar and sat change only when valid is set; between results they hold their values.
- The accumulator never wraps: it is WIDTH+1 bits, and its maximum value is N.

## Timing
- Reset (reset = 0, asynchronous): state = IDLE, busy = 0, valid = 0, scalar = 0, sat = 0, ones = 0, cnt = 0, applied immediately and independent of clk.
- Reset deassertion is synchronous in effect: the first accept can occur at the first rising edge with reset = 1.
- Latency: start accepted at edge t0 → valid high from just after edge t0+N-1 until edge t0+N; scalar is valid from edge t0+N-1.
- busy: high from after t0 to after t0+N-1 (N-1 cycles).
- Throughput: one result per N cycles when start is held high continuously.
- Reset mid-window: the window is aborted, no valid is produced, and the previous scalar/sat are cleared to 0.
- start held high through COUNT: has no effect until DONE, where it opens the next window.
- start pulse arriving during COUNT: lost; it is not queued.

## Test plan
- After reset, bs = 0 constant, start pulse → after 1024 cycles valid pulse, scalar = 0, sat = 0; busy high for exactly 1023 cycles.
- bs = 1 constant, start → scalar = 1023, sat = 1. Next window with bs = 0 → scalar = 0, sat = 0.
- bs driven by the 10-bit VDC generator at scalar 300, start at an arbitrary phase → scalar = 300. Repeat for 0, 1, 512 and 1023 → identical values returned.
- start held high for 3 windows; VDC scalar changed 700→41→999 at window boundaries (aligned to DONE edges) → three valid pulses 1024 cycles apart with those values; no gaps.
- reset asserted at cycle 500 of a window with bs = 1 → outputs 0 immediately, no valid. A new start after release gives the full count 1023/sat = 1.
- Extra start pulses at cycles 10 and 600 of an open window → ignored; a single valid at cycle 1023; block returns to IDLE.
